fp_mant_divider: RTL and testbench

Iterative restoring divider for 24-bit IEEE-754 single-precision mantissas. It sits directly downstream of the floating-point divide controller: it consumes the two hidden-bit-extended mantissas plus a start pulse, and returns a 23-bit normalized quotient fraction, an exponent-adjust flag and a zero flag. The controller handles sign, exponent, NaN/infinity and divide-by-zero classification; this block only produces the mantissa quotient, truncated toward zero.

---
 rtl/fp_mant_divider_pkg.sv | 24 ++
 rtl/fp_mant_divider_if.sv | 31 +++
 rtl/fp_mant_divider_step.sv | 26 ++
 rtl/fp_mant_divider.sv | 105 ++++++++++
 tb/tb_fp_mant_divider.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fp_mant_divider_pkg.sv
// fp_div_pkg: constants and types shared between the floating-point divide
// controller and the mantissa divider.
//   MANT_W / FRAC_W      mantissa width with and without the hidden bit
//   REM_W / CNT_W        partial remainder and iteration counter widths
//   OTHER_*_BIT          bit positions of the other_out status flags
//   div_state_e          one-hot divider FSM states
package fp_div_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned FRAC_W = MANT_W - 1;
    localparam int unsigned REM_W  = MANT_W + 1;
    localparam int unsigned CNT_W  = 5;

    localparam int unsigned OTHER_ZERO_BIT = 1;
    localparam int unsigned OTHER_NORM_BIT = 0;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        ITER = 4'b0100,
        DONE = 4'b1000
    } div_state_e;

endpackage

// File: rtl/fp_mant_divider_if.sv
// fp_mant_divider_if: request/response bundle between the divide controller
// (master) and the mantissa divider (slave).
//   trig        start pulse
//   data1_in    dividend mantissa {1,frac} or 0
//   data2_in    divisor mantissa {1,frac} or 0
//   result_out  quotient fraction, hidden bit dropped
//   other_out   {zero, quotient<1}
//   vld         one-cycle result strobe
//   busy        divider is not idle
interface fp_mant_divider_if;
    import fp_div_pkg::*;

    logic              trig;
    logic [MANT_W-1:0] data1_in;
    logic [MANT_W-1:0] data2_in;
    logic [FRAC_W-1:0] result_out;
    logic [1:0]        other_out;
    logic              vld;
    logic              busy;

    modport master (
        output trig, data1_in, data2_in,
        input  result_out, other_out, vld, busy
    );

    modport slave (
        input  trig, data1_in, data2_in,
        output result_out, other_out, vld, busy
    );

endinterface

// File: rtl/fp_mant_divider_step.sv
// mant_div_step: one restoring-division step, purely combinational.
//   rem       current partial remainder (always < 2*b)
//   b         divisor mantissa
//   q_bit     quotient bit produced by this step
//   rem_next  partial remainder for the next step, already shifted left
module mant_div_step
    import fp_div_pkg::*;
(
    input  logic [REM_W-1:0]  rem,
    input  logic [MANT_W-1:0] b,
    output logic              q_bit,
    output logic [REM_W-1:0]  rem_next
);

    logic [REM_W-1:0] b_ext;
    logic [REM_W-1:0] diff;

    always_comb begin
        b_ext    = {1'b0, b};
        diff     = rem - b_ext;
        q_bit    = (rem >= b_ext);
        // rem < 2*b keeps both shifted values inside REM_W bits
        rem_next = q_bit ? (diff << 1) : (rem << 1);
    end

endmodule

// File: rtl/fp_mant_divider.sv
// fp_mant_divider: iterative restoring divider for 24-bit single-precision
// mantissas. Produces a truncated 23-bit normalized quotient fraction, a
// quotient<1 flag (caller decrements exponent) and a zero-result flag.
//   sys_clk    clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        fp_mant_divider_if slave: trig/data1_in/data2_in in,
//              result_out/other_out/vld/busy out
module fp_mant_divider
    import fp_div_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    fp_mant_divider_if.slave    bus
);

    div_state_e        state;
    logic [MANT_W-1:0] a_r;
    logic [MANT_W-1:0] b_r;
    logic [REM_W-1:0]  rem;
    logic [FRAC_W-1:0] q;
    logic [CNT_W-1:0]  cnt;
    logic              zero_r;
    logic              norm_r;

    logic              q_bit;
    logic [REM_W-1:0]  rem_next;

    mant_div_step u_step (
        .rem      (rem),
        .b        (b_r),
        .q_bit    (q_bit),
        .rem_next (rem_next)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            a_r            <= '0;
            b_r            <= '0;
            rem            <= '0;
            q              <= '0;
            cnt            <= '0;
            zero_r         <= 1'b0;
            norm_r         <= 1'b0;
            bus.result_out <= '0;
            bus.other_out  <= '0;
            bus.vld        <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.trig) begin
                        a_r      <= bus.data1_in;
                        b_r      <= bus.data2_in;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (a_r == '0 || b_r == '0) begin
                        zero_r <= 1'b1;
                        norm_r <= 1'b0;
                        state  <= DONE;
                    end else begin
                        zero_r <= 1'b0;
                        // pre-shift a small dividend so the quotient MSB lands at bit 23
                        if (a_r < b_r) begin
                            norm_r <= 1'b1;
                            rem    <= {a_r, 1'b0};
                        end else begin
                            norm_r <= 1'b0;
                            rem    <= {1'b0, a_r};
                        end
                        q     <= '0;
                        cnt   <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    // q holds only the fraction: the always-1 hidden bit shifts out the top
                    q   <= {q[FRAC_W-2:0], q_bit};
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MANT_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.result_out <= zero_r ? '0 : q;
                    bus.other_out[OTHER_ZERO_BIT] <= zero_r;
                    bus.other_out[OTHER_NORM_BIT] <= norm_r;
                    bus.vld        <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mant_divider.sv
// tb_fp_mant_divider: directed and random checks of fp_mant_divider.
module tb_fp_mant_divider;
    import fp_div_pkg::*;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    fp_mant_divider_if bus ();

    fp_mant_divider dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] ref_q(input logic [23:0] a, input logic [23:0] b);
        logic [63:0] num;
        logic [63:0] quo;
        num = {40'b0, a};
        if (a >= b) quo = (num << 23) / {40'b0, b};
        else        quo = (num << 24) / {40'b0, b};
        return quo[22:0];
    endfunction

    // Called away from a clock edge; returns #1 after the trig edge (E0).
    task automatic start_op(input logic [23:0] a, input logic [23:0] b);
        bus.data1_in = a;
        bus.data2_in = b;
        bus.trig     = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.trig     = 1'b0;
    endtask

    // Returns the number of edges after E0 until vld is seen, 0 on timeout.
    task automatic wait_vld(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge sys_clk);
            #1;
            if (bus.vld) begin
                lat = i;
                break;
            end
        end
    endtask

    // Leaves the bench sitting in the vld cycle.
    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [22:0] exp_res, input logic [1:0] exp_oth,
                          input int exp_lat);
        int lat;
        start_op(a, b);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_vld(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(bus.result_out), 32'(exp_res));
        check({tag, " other"}, 32'(bus.other_out), 32'(exp_oth));
        check({tag, " busy in vld"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;
        int vld_cnt;
        logic [23:0] ra, rb;

        bus.trig     = 1'b0;
        bus.data1_in = '0;
        bus.data2_in = '0;

        #3;
        check("reset result", 32'(bus.result_out), 32'd0);
        check("reset other",  32'(bus.other_out),  32'd0);
        check("reset vld",    32'(bus.vld),        32'd0);
        check("reset busy",   32'(bus.busy),       32'd0);
        #19 sys_rst_n = 1'b1;
        @(negedge sys_clk);

        run_op("1.5/1.0", 24'hC00000, 24'h800000, 23'h400000, 2'b00, 26);
        @(posedge sys_clk); #1;
        check("vld width", 32'(bus.vld), 32'd0);

        run_op("1.0/1.5", 24'h800000, 24'hC00000, 23'h2AAAAA, 2'b01, 26);
        @(negedge sys_clk);
        run_op("max/1.0", 24'hFFFFFF, 24'h800000, 23'h7FFFFF, 2'b00, 26);
        @(negedge sys_clk);
        run_op("equal",   24'hA5A5A5, 24'hA5A5A5, 23'h000000, 2'b00, 26);
        @(negedge sys_clk);
        run_op("zero a",  24'h000000, 24'h900000, 23'h000000, 2'b10, 2);
        @(negedge sys_clk);
        run_op("zero b",  24'hC00000, 24'h000000, 23'h000000, 2'b10, 2);
        @(negedge sys_clk);

        // Extra trig pulses while busy must be ignored.
        start_op(24'h800000, 24'hC00000);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            bus.trig     = (i == 5 || i == 12 || i == 24);
            bus.data1_in = 24'hFFFFFF;
            bus.data2_in = 24'h000000;
            @(posedge sys_clk);
            #1;
            bus.trig = 1'b0;
            if (bus.vld) begin
                lat = i;
                break;
            end
        end
        check("ignore latency", 32'(lat), 32'd26);
        check("ignore result",  32'(bus.result_out), 32'h2AAAAA);
        check("ignore other",   32'(bus.other_out),  32'd1);
        vld_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge sys_clk); #1;
            if (bus.vld) vld_cnt++;
        end
        check("ignore no extra vld", 32'(vld_cnt), 32'd0);

        // Back-to-back: second trig issued in the first vld cycle.
        @(negedge sys_clk);
        run_op("b2b first",  24'hC00000, 24'h800000, 23'h400000, 2'b00, 26);
        run_op("b2b second", 24'h800000, 24'hC00000, 23'h2AAAAA, 2'b01, 26);
        @(negedge sys_clk);

        for (int k = 0; k < 8; k++) begin
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            run_op($sformatf("rand%0d", k), ra, rb, ref_q(ra, rb),
                   {1'b0, (ra < rb)}, 26);
            @(negedge sys_clk);
        end

        // Reset in ITER cycle 10 after a result with nonzero outputs.
        run_op("pre-reset", 24'hFFFFFF, 24'h800000, 23'h7FFFFF, 2'b00, 26);
        @(negedge sys_clk);
        start_op(24'hC00000, 24'h800000);
        repeat (11) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("midreset result", 32'(bus.result_out), 32'd0);
        check("midreset other",  32'(bus.other_out),  32'd0);
        check("midreset vld",    32'(bus.vld),        32'd0);
        check("midreset busy",   32'(bus.busy),       32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge sys_clk); #1;
            if (bus.vld) vld_cnt++;
        end
        check("midreset no vld", 32'(vld_cnt), 32'd0);
        @(negedge sys_clk);
        run_op("post-reset", 24'hC00000, 24'h800000, 23'h400000, 2'b00, 26);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
